// File: rtl/split_pkg.sv
// Shared types and defaults for the split-sample collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package split_pkg;

    localparam int CNT_W          = 16;
    localparam int SAMPLE_W_DEF   = 32;
    localparam int NUM_SPLITS_DEF = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EVAL  = 3'd2,
        PUSH  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Generic synchronous FIFO holding accepted samples.
// Latency: a push is visible at the head on the next cycle; the head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty.
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // The extra MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values; both advance independently so push+pop keeps occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/split_sample_collector.sv
// Collects candidates that satisfy every external split constraint until a target count is reached.
// Latency: candidate transfer to accept/reject decision is 1 cycle; accepted sample enters FIFO the cycle after.
// Backpressure: cand_ready only in FETCH; controller stalls in PUSH while the FIFO is full.
module split_sample_collector
    import split_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int NUM_SPLITS = NUM_SPLITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      target_cnt,
    input  logic                  cand_valid,
    output logic                  cand_ready,
    input  logic [SAMPLE_W-1:0]   cand_data,
    output logic [SAMPLE_W-1:0]   split_vars,
    input  logic [NUM_SPLITS-1:0] split_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SAMPLE_W-1:0]   out_data,
    output logic [CNT_W-1:0]      accept_cnt,
    output logic [CNT_W-1:0]      reject_cnt,
    output logic                  busy,
    output logic                  done
);

    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] split_vars_q, split_vars_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    rej_q, rej_d;
    logic [CNT_W-1:0]    target_q, target_d;
    logic [CNT_W-1:0]    acc_inc;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;

    assign acc_inc    = acc_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign split_vars = split_vars_q;
    assign accept_cnt = acc_q;
    assign reject_cnt = rej_q;
    assign out_valid  = !fifo_empty;

    // Controller next state and Moore outputs.
    always_comb begin
        state_d      = state_q;
        split_vars_d = split_vars_q;
        acc_d        = acc_q;
        rej_d        = rej_q;
        target_d     = target_q;
        fifo_push    = 1'b0;
        cand_ready   = (state_q == FETCH);
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    rej_d    = '0;
                    target_d = target_cnt;
                    state_d  = (target_cnt == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (cand_valid) begin
                    split_vars_d = cand_data;
                    state_d      = EVAL;
                end
            end
            EVAL: begin
                // Accept only when every split reports its constraint satisfied.
                if (&split_x) begin
                    state_d = PUSH;
                end else begin
                    rej_d   = sat_inc(rej_q);
                    state_d = FETCH;
                end
            end
            PUSH: begin
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    acc_d     = acc_inc;
                    state_d   = (acc_inc == target_q) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers; reset abandons any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            split_vars_q <= '0;
            acc_q        <= '0;
            rej_q        <= '0;
            target_q     <= '0;
        end else begin
            state_q      <= state_d;
            split_vars_q <= split_vars_d;
            acc_q        <= acc_d;
            rej_q        <= rej_d;
            target_q     <= target_d;
        end
    end

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (split_vars_q),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_split_sample_collector.sv
// Randomized bench for split_sample_collector with a queue-based reference model.
// Latency: n/a.
// Backpressure: out_ready driven fixed-low, fixed-high or random per scenario.
module tb_split_sample_collector;

    localparam int SW = 32;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   target_cnt = '0;
    logic          cand_valid = 1'b0;
    logic          cand_ready;
    logic [SW-1:0] cand_data = '0;
    logic [SW-1:0] split_vars;
    logic [NS-1:0] split_x;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_data;
    logic [15:0]   accept_cnt, reject_cnt;
    logic          busy, done;

    bit all_ones = 1'b1;
    bit use_dir  = 1'b0;
    int rdy_mode = 1;     // 0 = low, 1 = high, 2 = random

    always #5 clk = ~clk;

    split_sample_collector #(.SAMPLE_W(SW), .NUM_SPLITS(NS), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .target_cnt (target_cnt),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .cand_data  (cand_data),
        .split_vars (split_vars),
        .split_x    (split_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .accept_cnt (accept_cnt),
        .reject_cnt (reject_cnt),
        .busy       (busy),
        .done       (done)
    );

    // Stand-in constraint blocks: split i holds when bits [8i+1:8i] are not both zero.
    function automatic logic [NS-1:0] constraint_fn(input logic [SW-1:0] v);
        logic [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = (v[i*8 +: 2] != 2'b00);
        return r;
    endfunction

    assign split_x = all_ones ? {NS{1'b1}} : constraint_fn(split_vars);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] dir_q[$];
    int  m_target = 0;
    int  m_acc    = 0;
    int  m_rej    = 0;
    int  n_out    = 0;
    int  n_done   = 0;
    bit  taken    = 1'b0;
    bit  prev_done = 1'b0;

    // Monitor: inputs change at posedge+1, so the negedge sees what the next posedge will consume.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_done) chk("done_width", done, 0);
                prev_done = done;
                if (cand_valid && cand_ready) begin
                    taken = 1'b1;
                    if (all_ones || constraint_fn(cand_data) == {NS{1'b1}}) begin
                        exp_q.push_back(cand_data);
                        m_acc++;
                    end else begin
                        m_rej++;
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
                    else                   chk("out_data", out_data, exp_q.pop_front());
                    n_out++;
                end
                if (done) begin
                    n_done++;
                    chk("done_acc", accept_cnt, m_target);
                    chk("done_rej", reject_cnt, m_rej);
                    chk("model_acc", m_acc, m_target);
                end
            end
        end
    end

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        if (!cand_valid || taken) begin
            taken = 1'b0;
            if (use_dir) begin
                cand_valid = (dir_q.size() > 0);
                if (dir_q.size() > 0) cand_data = dir_q.pop_front();
            end else begin
                cand_valid = ($urandom_range(0, 3) != 0);
                cand_data  = $urandom;
            end
        end
        out_ready = (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
    endtask

    task automatic start_run(input int tgt);
        @(posedge clk);
        #1;
        target_cnt = tgt[15:0];
        start      = 1'b1;
        m_target   = tgt;
        m_acc      = 0;
        m_rej      = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int d0 = n_done;
        for (int i = 0; i < bound && n_done == d0; i++) drive_cycle();
        chk({tag, "_done_seen"}, n_done - d0, 1);
        cand_valid = 1'b0;
        taken      = 1'b0;
    endtask

    task automatic drain(input int bound, input string tag);
        rdy_mode  = 1;
        out_ready = 1'b1;
        for (int i = 0; i < bound && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        chk({tag, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        chk({tag, "_outv_idle"}, out_valid, 0);
    endtask

    initial begin
        int n0;
        // Reset state, checked before any clock edge
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cand_ready", cand_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_split_vars", split_vars, 0);
        chk("rst_acc", accept_cnt, 0);
        chk("rst_rej", reject_cnt, 0);
        #20 rst_n = 1'b1;

        // Three samples, all accepted, in order
        all_ones = 1'b1; rdy_mode = 1; n0 = n_out;
        start_run(3);
        wait_done(200, "basic");
        drain(50, "basic");
        chk("basic_nout", n_out - n0, 3);
        chk("basic_rej", reject_cnt, 0);
        chk("basic_acc", accept_cnt, 3);

        // Middle candidate fails split 3 and is rejected
        all_ones = 1'b0; use_dir = 1'b1; n0 = n_out;
        dir_q.push_back(32'hFFFF_FFFF);
        dir_q.push_back(32'hFCFF_FFFF);
        dir_q.push_back(32'hFFFF_FFFE);
        start_run(2);
        wait_done(200, "reject");
        drain(50, "reject");
        use_dir = 1'b0;
        chk("reject_nout", n_out - n0, 2);
        chk("reject_rej", reject_cnt, 1);

        // FIFO full stalls the controller in PUSH after four accepts
        all_ones = 1'b1; rdy_mode = 0; n0 = n_out;
        start_run(6);
        repeat (80) drive_cycle();
        @(negedge clk);
        chk("stall_cand_ready", cand_ready, 0);
        chk("stall_acc", accept_cnt, 4);
        chk("stall_busy", busy, 1);
        chk("stall_nout", n_out - n0, 0);
        rdy_mode = 1;
        wait_done(300, "stall");
        drain(50, "stall");
        chk("stall_nout_final", n_out - n0, 6);

        // Zero target finishes immediately without consuming candidates
        cand_valid = 1'b1; cand_data = 32'h1234_5678;
        start_run(0);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_acc", accept_cnt, 0);
        chk("zero_rej", reject_cnt, 0);
        @(negedge clk);
        chk("zero_cand_ready", cand_ready, 0);
        cand_valid = 1'b0;

        // Reset in EVAL with two samples buffered
        all_ones = 1'b1; rdy_mode = 0;
        start_run(5);
        for (int i = 0; i < 200 && m_acc < 3; i++) drive_cycle();
        cand_valid = 1'b0; taken = 1'b0;
        chk("pre_rst_outv", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outv", out_valid, 0);
        chk("midrst_acc", accept_cnt, 0);
        chk("midrst_rej", reject_cnt, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_split_vars", split_vars, 0);
        exp_q.delete();
        prev_done = 1'b0;
        #13 rst_n = 1'b1;
        rdy_mode = 1; n0 = n_out;
        start_run(2);
        wait_done(200, "postrst");
        drain(50, "postrst");
        chk("postrst_nout", n_out - n0, 2);

        // Start while busy must not restart or relatch the target
        all_ones = 1'b1; rdy_mode = 1; n0 = n_out;
        start_run(3);
        drive_cycle();
        drive_cycle();
        @(posedge clk); #1;
        target_cnt = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, "busystart");
        drain(50, "busystart");
        chk("busystart_nout", n_out - n0, 3);

        // Random runs against the constraint function with random backpressure
        all_ones = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rdy_mode = 2; n0 = n_out;
            start_run($urandom_range(1, 8));
            wait_done(3000, "rand");
            drain(100, "rand");
            chk("rand_nout", n_out - n0, m_target);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/split_sample_collector.md
SPLIT_SAMPLE_COLLECTOR -- requirements
Module: split_sample_collector

Interface
REQ-001: Parameter SAMPLE_W, default 32, width of one packed candidate assignment of the constraint variables.
REQ-002: Parameter NUM_SPLITS, default 4, number of constraint-split results evaluated per candidate.
REQ-003: Parameter FIFO_DEPTH, default 4, power of two, accepted-sample buffer depth.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006: start  input  1  one-cycle pulse; begins a collection run, sampled only in IDLE.
REQ-007: target_cnt  input  16  number of accepted samples required; sampled at start.
REQ-008: cand_valid / cand_ready  input / output  1 / 1  candidate handshake; a transfer occurs when both are high.
REQ-009: cand_data  input  SAMPLE_W  candidate variable assignment.
REQ-010: split_vars  output  SAMPLE_W  registered assignment driving the combinational split-constraint blocks.
REQ-011: split_x  input  NUM_SPLITS  per-split constraint result (1 = satisfied), combinational from split_vars.
REQ-012: out_valid / out_ready  output / input  1 / 1  accepted-sample handshake.
REQ-013: out_data  output  SAMPLE_W  accepted assignment at FIFO head.
REQ-014: accept_cnt, reject_cnt  output  16 each  run statistics.
REQ-015: busy  output  1  high in any state other than IDLE; done  output  1  one-cycle pulse at run completion.

Function
REQ-016: The controller SHALL implement states IDLE, FETCH, EVAL, PUSH, DONE.
REQ-017: IDLE -> FETCH on start; accept_cnt and reject_cnt SHALL clear to 0 and target_cnt SHALL be latched in the same cycle.
REQ-018: In IDLE, start with target_cnt == 0 SHALL go directly to DONE.
REQ-019: cand_ready SHALL be high only in FETCH; on transfer cand_data SHALL be registered into split_vars and the state SHALL go to EVAL.
REQ-020: In EVAL, the sample SHALL be accepted iff all NUM_SPLITS bits of split_x are 1; evaluation latency from candidate transfer to decision is exactly 1 cycle.
REQ-021: Rejected candidate: reject_cnt increments (saturating at 16'hFFFF), next state FETCH.
REQ-022: Accepted candidate: next state PUSH; in PUSH, if the FIFO is not full, split_vars SHALL be written, accept_cnt increments, then DONE if accept_cnt+1 == latched target else FETCH; if full, PUSH SHALL stall with no counter change.
REQ-023: DONE SHALL assert done for exactly one cycle and return to IDLE; start during DONE is ignored.
REQ-024: start while busy SHALL be ignored.
REQ-025: split_vars SHALL hold its value outside the FETCH transfer cycle.
REQ-026: out_valid = FIFO not empty; out_data = FIFO head; pop when out_valid & out_ready; FIFO drains independently of controller state, including after DONE.
REQ-027: Simultaneous push and pop on a full FIFO SHALL not occur (push is gated by full); simultaneous push and pop on a non-full, non-empty FIFO SHALL keep occupancy unchanged.
REQ-028: FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH using one extra bit for full/empty distinction.

Reset
REQ-029: On rst_n low, state SHALL be IDLE, split_vars 0, counters 0, FIFO empty, cand_ready 0, out_valid 0, busy 0, done 0, asynchronously.
REQ-030: Reset mid-run SHALL abandon the run and discard all buffered samples; no done pulse is produced.

Structure
REQ-031: State enum, counter width (16) and default parameters SHALL live in shared package split_pkg.
REQ-032: The buffer SHALL be a separate sub-module sample_fifo (parameters WIDTH, DEPTH; push/pop/full/empty).
REQ-033: Split-constraint blocks are instantiated outside this module; no constraint logic inside.

Verification
REQ-034: target_cnt=3, split_x tied all-ones, out_ready=1 -> 3 samples out in candidate order, accept_cnt=3, reject_cnt=0, one done pulse.
REQ-035: target_cnt=2, split_x pattern per candidate 4'hF,4'h7,4'hF -> outputs candidates 1 and 3, reject_cnt=1.
REQ-036: target_cnt=6, out_ready=0 -> after 4 accepts state stalls in PUSH, cand_ready low; raising out_ready completes run with accept_cnt=6.
REQ-037: target_cnt=0 -> done pulse 1 cycle after start, no candidate consumed, counters 0.
REQ-038: rst_n pulsed low in EVAL with 2 samples buffered -> out_valid 0, counters 0, state IDLE; following start runs normally.
REQ-039: start pulsed while busy -> no effect on counters or latched target.
